// File: rtl/snd_dac_ctrl.sv
// snd_dac_ctrl: feeds a sigma-delta DAC from two sample requesters.
//   A 4-entry FIFO is shared by two requesters under round-robin arbitration
//   when both are valid. One sample is popped per sample period. Samples are
//   converted from two's complement to excess-512. A mute state machine ramps
//   the output to and from midscale so that muting does not click.
// Ports:
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_a_valid/i_a_data/o_a_ready     requester A handshake (signed 10-bit)
//   i_b_valid/i_b_data/o_b_ready     requester B handshake (signed 10-bit)
//   i_mute                           1: ramp to midscale, 0: ramp back to audio
//   i_err_clr                        clears o_underrun
//   o_dac_in                         registered excess-512 DAC code
//   o_sample_tick                    one-cycle pulse per sample period
//   o_muted                          high while fully muted
//   o_underrun                       sticky: a tick found the FIFO empty
module snd_dac_ctrl #(
  parameter int RATE_DIV  = 256,
  parameter int RAMP_STEP = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_a_valid,
  input  logic [9:0] i_a_data,
  output logic       o_a_ready,
  input  logic       i_b_valid,
  input  logic [9:0] i_b_data,
  output logic       o_b_ready,
  input  logic       i_mute,
  input  logic       i_err_clr,
  output logic [9:0] o_dac_in,
  output logic       o_sample_tick,
  output logic       o_muted,
  output logic       o_underrun
);

  localparam int            CW       = $clog2(RATE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(RATE_DIV - 2);
  localparam logic [10:0]   STEP     = 11'(RAMP_STEP);
  localparam logic [9:0]    MID      = 10'h200;

  typedef enum logic [1:0] {S_MUTED, S_RAMP_UP, S_RUN, S_RAMP_DOWN} state_t;

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [9:0]    r_mem [4];
  logic [1:0]    r_wr_ptr, r_rd_ptr;
  logic [2:0]    r_count;
  logic          r_prio;       // 0: A wins a contested grant, 1: B wins
  logic [9:0]    r_target;
  logic [9:0]    r_dac;
  logic          r_underrun;
  state_t        r_state, w_state_n;

  logic       w_full, w_empty, w_grant_a, w_grant_b, w_push, w_pop;
  logic [9:0] w_push_data, w_pop_code, w_new_target, w_goal, w_ramp_dac, w_dac_n;
  logic [10:0] w_dac11, w_goal11, w_dist, w_amt;
  logic       w_up, w_reach;

  // Tick is registered one cycle ahead so it coincides with r_cnt == RATE_DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == CNT_PRE);
    end
  end

  // Arbitration uses the registered count, so a slot freed by a pop is only
  // offered on the following cycle.
  assign w_full      = (r_count == 3'd4);
  assign w_empty     = (r_count == 3'd0);
  assign w_grant_a   = !i_reset && !w_full && i_a_valid && (!i_b_valid || !r_prio);
  assign w_grant_b   = !i_reset && !w_full && i_b_valid && (!i_a_valid ||  r_prio);
  assign w_push      = w_grant_a || w_grant_b;
  assign w_push_data = w_grant_a ? i_a_data : i_b_data;
  assign w_pop       = r_tick && !w_empty;
  assign o_a_ready   = w_grant_a;
  assign o_b_ready   = w_grant_b;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
      if (w_push && i_a_valid && i_b_valid) r_prio <= !r_prio;
    end
  end

  // Two's complement to excess-512: flip the sign bit.
  assign w_pop_code   = {~r_mem[r_rd_ptr][9], r_mem[r_rd_ptr][8:0]};
  assign w_new_target = w_pop ? w_pop_code : r_target;

  // Shared ramp datapath: step toward the goal by min(STEP, distance).
  assign w_goal     = (r_state == S_RAMP_DOWN) ? MID : w_new_target;
  assign w_dac11    = {1'b0, r_dac};
  assign w_goal11   = {1'b0, w_goal};
  assign w_up       = (w_goal11 >= w_dac11);
  assign w_dist     = w_up ? (w_goal11 - w_dac11) : (w_dac11 - w_goal11);
  assign w_reach    = (w_dist <= STEP);
  assign w_amt      = w_reach ? w_dist : STEP;
  assign w_ramp_dac = w_up ? 10'(w_dac11 + w_amt) : 10'(w_dac11 - w_amt);

  // Mute-driven transitions are checked last so they override a ramp completing
  // in the same cycle.
  always_comb begin
    w_state_n = r_state;
    w_dac_n   = r_dac;
    case (r_state)
      S_MUTED: begin
        w_dac_n = MID;
        if (!i_mute) w_state_n = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (r_tick) begin
          w_dac_n = w_ramp_dac;
          if (w_reach) w_state_n = S_RUN;
        end
        if (i_mute) w_state_n = S_RAMP_DOWN;
      end
      S_RUN: begin
        if (r_tick) w_dac_n = w_new_target;
        if (i_mute) w_state_n = S_RAMP_DOWN;
      end
      default: begin
        if (r_tick) begin
          w_dac_n = w_ramp_dac;
          if (w_reach) w_state_n = S_MUTED;
        end
        if (!i_mute) w_state_n = S_RAMP_UP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_MUTED;
      r_dac      <= MID;
      r_target   <= MID;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_dac   <= w_dac_n;
      // Samples popped while muting or muted are dropped.
      if (w_pop && (r_state == S_RUN || r_state == S_RAMP_UP))
        r_target <= w_pop_code;
      if (r_tick && w_empty) r_underrun <= 1'b1;
      else if (i_err_clr)    r_underrun <= 1'b0;
    end
  end

  assign o_dac_in      = r_dac;
  assign o_sample_tick = r_tick;
  assign o_muted       = (r_state == S_MUTED);
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_snd_dac_ctrl.sv
// Bench for snd_dac_ctrl: arbitration vector table, randomized traffic against
// a queue-based reference model, and directed ramp / underrun / reset sequences.
module tb_snd_dac_ctrl;

  localparam int RD   = 8;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_v = 1'b0, b_v = 1'b0, mute = 1'b1, err_clr = 1'b0;
  logic [9:0] a_d = '0, b_d = '0;
  logic       a_rdy, b_rdy, tick, muted, urun;
  logic [9:0] dac;

  snd_dac_ctrl #(.RATE_DIV(RD), .RAMP_STEP(STEP)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_a_valid(a_v), .i_a_data(a_d), .o_a_ready(a_rdy),
    .i_b_valid(b_v), .i_b_data(b_d), .o_b_ready(b_rdy),
    .i_mute(mute), .i_err_clr(err_clr),
    .o_dac_in(dac), .o_sample_tick(tick), .o_muted(muted), .o_underrun(urun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_MUTED = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;
  int m_cnt = 0, m_dac = 512, m_tgt = 512, m_st = M_MUTED, m_ptr = 0;
  bit m_urun = 0;
  int q[$];

  function automatic int approach(input int x, input int g);
    int d;
    d = (g > x) ? g - x : x - g;
    if (d > STEP) d = STEP;
    return (g > x) ? x + d : x - d;
  endfunction

  function automatic bit m_ar();
    return !reset && q.size() < 4 && a_v && (!b_v || m_ptr == 0);
  endfunction
  function automatic bit m_br();
    return !reset && q.size() < 4 && b_v && (!a_v || m_ptr == 1);
  endfunction

  task automatic m_step();
    bit ar, br, tk, popped;
    int nt, st0;
    if (reset) begin
      m_cnt = 0; m_dac = 512; m_tgt = 512; m_st = M_MUTED; m_ptr = 0; m_urun = 0;
      q.delete();
      return;
    end
    ar = m_ar(); br = m_br();
    tk = (m_cnt == RD - 1);
    popped = 0; nt = m_tgt;
    if (tk && q.size() > 0) begin popped = 1; nt = q.pop_front() ^ 'h200; end
    if (ar || br) begin
      q.push_back(ar ? int'(a_d) : int'(b_d));
      if (a_v && b_v) m_ptr = 1 - m_ptr;
    end
    if (tk && !popped) m_urun = 1;
    else if (err_clr)  m_urun = 0;
    st0 = m_st;
    if (st0 == M_RUN || st0 == M_UP) m_tgt = nt;
    if (tk) begin
      if (st0 == M_RUN) m_dac = nt;
      else if (st0 == M_UP) begin
        m_dac = approach(m_dac, nt);
        if (m_dac == nt) m_st = M_RUN;
      end else if (st0 == M_DOWN) begin
        m_dac = approach(m_dac, 512);
        if (m_dac == 512) m_st = M_MUTED;
      end
    end
    if (mute && (st0 == M_RUN || st0 == M_UP))     m_st = M_DOWN;
    if (!mute && (st0 == M_DOWN || st0 == M_MUTED)) m_st = M_UP;
    m_cnt = (m_cnt + 1) % RD;
  endtask

  // One clock: compare mid-cycle, advance model on the edge, return 1 after it.
  task automatic cyc();
    #4;
    chk("dac",      16'(dac),   16'(m_dac));
    chk("tick",     16'(tick),  16'(m_cnt == RD - 1));
    chk("muted",    16'(muted), 16'(m_st == M_MUTED));
    chk("underrun", 16'(urun),  16'(m_urun));
    chk("a_ready",  16'(a_rdy), 16'(m_ar()));
    chk("b_ready",  16'(b_rdy), 16'(m_br()));
    @(posedge clk);
    m_step();
    #1;
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct { bit rst, av, bv, ar, br, tk; } vec_t;
  vec_t tbl[11];

  initial begin : main
    bit found;
    tbl[0]  = '{1, 1, 1, 0, 0, 0};  // readys held low in reset
    tbl[1]  = '{0, 1, 1, 1, 0, 0};  // contested, pointer starts at A
    tbl[2]  = '{0, 1, 1, 0, 1, 0};  // alternates to B
    tbl[3]  = '{0, 0, 1, 0, 1, 0};  // uncontested B, pointer stays at A
    tbl[4]  = '{0, 1, 1, 1, 0, 0};  // fourth entry
    tbl[5]  = '{0, 1, 1, 0, 0, 0};  // full
    tbl[6]  = '{0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 1};  // tick pops but still full this cycle
    tbl[9]  = '{0, 1, 1, 0, 1, 0};  // freed slot used next cycle
    tbl[10] = '{0, 1, 1, 0, 0, 0};

    @(posedge clk); m_step(); #1;
    chk("rst_dac",   16'(dac),   16'h200);
    chk("rst_muted", 16'(muted), 16'h1);
    chk("rst_urun",  16'(urun),  16'h0);
    chk("rst_tick",  16'(tick),  16'h0);

    a_d = 10'h011; b_d = 10'h3F0;
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; a_v = tbl[i].av; b_v = tbl[i].bv;
      #3;
      chk($sformatf("tbl%0d_a_ready", i), 16'(a_rdy), 16'(tbl[i].ar));
      chk($sformatf("tbl%0d_b_ready", i), 16'(b_rdy), 16'(tbl[i].bv & tbl[i].br));
      chk($sformatf("tbl%0d_tick", i),    16'(tick),  16'(tbl[i].tk));
      cyc();
    end

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 999) == 0);
      a_v     = ($urandom_range(0, 3) != 0);
      b_v     = ($urandom_range(0, 2) == 0);
      a_d     = 10'($urandom);
      b_d     = 10'($urandom);
      err_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) mute = !mute;
      cyc();
    end
    err_clr = 0; b_v = 0;

    // ---------------- ramp up from reset with A = 0x100 ----------------
    reset = 1; mute = 0; a_v = 1; a_d = 10'h100;
    cyc();
    reset = 0;
    repeat (63 * RD) cyc();
    chk("ramp_up_63", 16'(dac), 16'h2FC);
    chk("ramp_up_muted", 16'(muted), 16'h0);
    repeat (RD) cyc();
    chk("ramp_up_64", 16'(dac), 16'h300);

    // ---------------- run at 0x3FF, then ramp down ----------------
    a_d = 10'h1FF;
    repeat (6 * RD) cyc();
    chk("run_3ff", 16'(dac), 16'h3FF);
    mute = 1;
    repeat (RD) cyc();
    chk("ramp_dn_1", 16'(dac), 16'h3FB);
    repeat (130 * RD) cyc();
    chk("ramp_dn_end", 16'(dac), 16'h200);
    chk("ramp_dn_muted", 16'(muted), 16'h1);

    // ---------------- underrun and ERR_CLR ----------------
    a_d = 10'h010;
    repeat (5 * RD) cyc();
    mute = 0;
    repeat (8 * RD) cyc();
    chk("run_210", 16'(dac), 16'h210);
    a_v = 0;
    repeat (8 * RD) cyc();
    chk("urun_set", 16'(urun), 16'h1);
    chk("urun_hold", 16'(dac), 16'h210);
    err_clr = 1; cyc(); err_clr = 0;
    chk("urun_clr", 16'(urun), 16'h0);
    for (int k = 0; k < RD && m_cnt != RD - 1; k++) cyc();
    err_clr = 1; cyc(); err_clr = 0;
    chk("urun_set_wins", 16'(urun), 16'h1);

    // ---------------- reversal at 0x280, then reset mid ramp-up ----------------
    a_v = 1; a_d = 10'h0C0;
    repeat (6 * RD) cyc();
    chk("run_2c0", 16'(dac), 16'h2C0);
    mute = 1;
    found = 0;
    for (int k = 0; k < 40 * RD && !found; k++) begin
      cyc();
      if (m_dac == 'h280) found = 1;
    end
    chk("reach_280", 16'(found), 16'h1);
    chk("at_280", 16'(dac), 16'h280);
    mute = 0;
    repeat (2 * RD) cyc();
    chk("reverse_288", 16'(dac), 16'h288);
    chk("reverse_not_muted", 16'(muted), 16'h0);
    reset = 1;
    #3;
    chk("rst_a_ready", 16'(a_rdy), 16'h0);
    cyc();
    reset = 0;
    chk("rst2_dac", 16'(dac), 16'h200);
    chk("rst2_muted", 16'(muted), 16'h1);
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/snd_dac_ctrl.md
SND_DAC_CTRL -- requirements
Module: snd_dac_ctrl

Interface
REQ-001 SHALL have parameter RATE_DIV, default 256, CLK cycles per output sample period (legal range 4..65535).
REQ-002 SHALL have parameter RAMP_STEP, default 4, maximum code change per sample tick during a mute ramp (legal range 1..511).
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 A_VALID / A_DATA[9:0] / A_READY  in/in/out  1/10/1  requester A sample handshake; data is two's-complement signed.
REQ-006 B_VALID / B_DATA[9:0] / B_READY  in/in/out  1/10/1  requester B sample handshake; same format.
REQ-007 MUTE  in  1  level: 1 requests ramp to midscale and silence; 0 requests ramp back to live audio.
REQ-008 DAC_IN  out  10  registered excess-512 code for the sigma-delta DAC input.
REQ-009 SAMPLE_TICK  out  1  registered one-cycle pulse marking each sample period.
REQ-010 MUTED  out  1  high while state is MUTED.
REQ-011 UNDERRUN  out  1  sticky flag: a tick found the FIFO empty.
REQ-012 ERR_CLR  in  1  clears UNDERRUN.

Function
REQ-013 Tick counter SHALL count 0..RATE_DIV-1 and wrap; SAMPLE_TICK SHALL be 1 in the cycle in which the counter equals RATE_DIV-1.
REQ-014 Shared 4-entry FIFO, 10-bit entries; at most one push per cycle; at most one pop per cycle, and only in a tick cycle.
REQ-015 Arbitration: when the FIFO is not full, grant goes to the only valid requester; if both are valid, grant goes to the requester named by the priority pointer.
REQ-016 Pointer SHALL toggle to the other requester after every contested grant and SHALL be unchanged after an uncontested grant.
REQ-017 X_READY SHALL be 1 only for the granted requester; a transfer occurs when X_VALID and X_READY are both 1.
REQ-018 Full FIFO: both READYs 0, even in a cycle with a simultaneous pop; the freed slot is usable from the next cycle.
REQ-019 Pushed data SHALL be poppable no earlier than the cycle after the push; push and pop in the same cycle on a non-empty, non-full FIFO SHALL both occur.
REQ-020 Conversion: excess code = sample with bit 9 inverted (e.g. 0x000->0x200, 0x1FF->0x3FF, 0x200->0x000).
REQ-021 Pops SHALL occur on every tick in every state; in RAMP_DOWN and MUTED the popped sample is discarded.
REQ-022 Tick with empty FIFO: no pop, target = previous target, UNDERRUN set in the next cycle; a simultaneous ERR_CLR loses to the set.
REQ-023 States: MUTED, RAMP_UP, RUN, RAMP_DOWN; DAC_IN changes only in the cycle after a tick (1-cycle latency from pop).
REQ-024 RUN: DAC_IN <= target; MUTE=1 -> RAMP_DOWN.
REQ-025 RAMP_DOWN: DAC_IN moves toward 0x200 by min(RAMP_STEP, distance); on reaching 0x200 -> MUTED; MUTE=0 -> RAMP_UP.
REQ-026 MUTED: DAC_IN holds 0x200; MUTE=0 -> RAMP_UP.
REQ-027 RAMP_UP: if |target-DAC_IN| <= RAMP_STEP, DAC_IN <= target and state -> RUN; otherwise DAC_IN moves RAMP_STEP toward target; MUTE=1 -> RAMP_DOWN.
REQ-028 MUTE-driven transitions SHALL be evaluated every cycle; ramp steps occur only on ticks.
REQ-029 Ramp arithmetic SHALL use 11-bit unsigned compare/subtract; DAC_IN SHALL never leave 0x000..0x3FF.

Reset
REQ-030 RESET SHALL take effect at the next edge regardless of state, aborting any ramp or transfer.
REQ-031 After reset: DAC_IN=0x200; state MUTED; MUTED=1; FIFO empty; target=0x200; tick counter=0; SAMPLE_TICK=0; UNDERRUN=0; pointer=A.
REQ-032 READYs SHALL be 0 while RESET=1.

Verification
REQ-033 Reset, MUTE=0, push A=0x100 each period, RAMP_STEP=4 -> DAC_IN 0x200,0x204,...,0x2FC, then 0x300 on the 64th tick (0x300 is first reached there); MUTED 1->0.
REQ-034 A and B both valid continuously, FIFO draining -> grants alternate A,B,A,B starting with A; no double grant in a cycle.
REQ-035 Fill 4 entries, hold both valid -> both READYs 0 through the tick cycle; one push the cycle after the pop.
REQ-036 RUN at 0x3FF, MUTE=1 -> DAC_IN 0x3FB,0x3F7,... per tick to 0x200, then MUTED=1.
REQ-037 RUN with empty FIFO at tick -> DAC_IN holds, UNDERRUN=1; ERR_CLR pulse clears it; ERR_CLR on an empty tick leaves it 1.
REQ-038 MUTE toggled 1->0 mid RAMP_DOWN at 0x280, then RESET mid RAMP_UP -> ramp reverses upward from 0x280; after reset DAC_IN=0x200, MUTED=1.
